// File: rtl/mem_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_request_arbiter
//  Description : Arbitrates instruction-fetch and data requests onto a single
//                req/ack memory bus. Builds byte enables and lane-replicated
//                store data, aligns and extends load data, flags misaligned
//                or illegal data accesses, aborts bus cycles on timeout and
//                stalls the core while a request is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  // instruction fetch side
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  output logic                i_err,
  // data side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [1:0]          d_size,
  input  logic                d_unsigned,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_err,
  // memory bus
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  // core stall
  output logic                stall
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Lane arithmetic below assumes a four-byte bus.
  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("mem_request_arbiter: only DATA_W=32 is supported");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("mem_request_arbiter: TIMEOUT must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    D_ERR  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // last_d: 1 when the most recent grant went to the data side
  logic              last_d, last_d_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  // access attributes captured at grant, used to shape the load result
  logic [1:0]        off, off_nxt;
  logic [1:0]        size, size_nxt;
  logic              uns, uns_nxt;

  logic              m_req_nxt, m_we_nxt;
  logic [ADDR_W-1:0] m_addr_nxt;
  logic [DATA_W-1:0] m_wdata_nxt;
  logic [BE_W-1:0]   m_be_nxt;
  logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
  logic              i_done_nxt, d_done_nxt, i_err_nxt, d_err_nxt;

  // decoded data request and shaped load data
  logic              d_bad;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_lanes;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_val;

  // arbitration
  logic              i_want, d_want, grant_i, grant_d;
  logic              timed_out;

  // fetch addresses are word aligned; their low bits carry no information
  logic              unused_ibits;
  assign unused_ibits = ^i_addr[1:0];

  // Stall while either side has a request whose completion has not yet pulsed.
  assign stall = (i_req & ~i_done) | (d_req & ~d_done);

  // A side whose done is pulsing this cycle still holds its request; mask it
  // so the same request is not granted a second time.
  assign i_want  = i_req & ~i_done;
  assign d_want  = d_req & ~d_done;
  assign grant_d = d_want & (~i_want | ~last_d);
  assign grant_i = i_want & ~grant_d;

  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  // Decode the incoming data request: legality, byte enables, store lanes.
  always_comb begin
    d_bad   = 1'b0;
    d_be    = '1;
    d_lanes = d_wdata;
    case (d_size)
      SIZE_BYTE: begin
        d_be    = BE_W'(1) << d_addr[1:0];
        d_lanes = {BE_W{d_wdata[7:0]}};
      end
      SIZE_HALF: begin
        d_bad   = d_addr[0];
        d_be    = BE_W'(3) << d_addr[1:0];
        d_lanes = {(BE_W/2){d_wdata[15:0]}};
      end
      SIZE_WORD: begin
        d_bad   = (d_addr[1:0] != 2'b00);
      end
      default: begin
        d_bad   = 1'b1;
      end
    endcase
  end

  // Align returning read data to bit 0, then truncate and extend by size.
  always_comb begin
    rd_shift = m_rdata >> {off, 3'b000};
    load_val = rd_shift;
    case (size)
      SIZE_BYTE: load_val = uns ? {{(DATA_W-8){1'b0}}, rd_shift[7:0]}
                                : {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
      SIZE_HALF: load_val = uns ? {{(DATA_W-16){1'b0}}, rd_shift[15:0]}
                                : {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
      default:   load_val = rd_shift;
    endcase
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_nxt   = state;
    last_d_nxt  = last_d;
    cnt_nxt     = cnt;
    off_nxt     = off;
    size_nxt    = size;
    uns_nxt     = uns;
    m_req_nxt   = m_req;
    m_we_nxt    = m_we;
    m_addr_nxt  = m_addr;
    m_wdata_nxt = m_wdata;
    m_be_nxt    = m_be;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    i_done_nxt  = 1'b0;
    d_done_nxt  = 1'b0;
    i_err_nxt   = 1'b0;
    d_err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          last_d_nxt = 1'b1;
          cnt_nxt    = '0;
          off_nxt    = d_addr[1:0];
          size_nxt   = d_size;
          uns_nxt    = d_unsigned;
          if (d_bad) begin
            // illegal access never reaches the bus
            state_nxt = D_ERR;
          end else begin
            state_nxt   = D_BUSY;
            m_req_nxt   = 1'b1;
            m_we_nxt    = d_we;
            m_addr_nxt  = {d_addr[ADDR_W-1:2], 2'b00};
            m_be_nxt    = d_be;
            m_wdata_nxt = d_we ? d_lanes : '0;
          end
        end else if (grant_i) begin
          last_d_nxt  = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = I_BUSY;
          m_req_nxt   = 1'b1;
          m_we_nxt    = 1'b0;
          m_addr_nxt  = {i_addr[ADDR_W-1:2], 2'b00};
          m_be_nxt    = '1;
          m_wdata_nxt = '0;
        end
      end

      I_BUSY: begin
        if (m_ack) begin
          m_req_nxt   = 1'b0;
          i_done_nxt  = 1'b1;
          i_rdata_nxt = m_rdata;
          state_nxt   = IDLE;
        end else if (timed_out) begin
          m_req_nxt   = 1'b0;
          i_done_nxt  = 1'b1;
          i_err_nxt   = 1'b1;
          i_rdata_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end

      D_BUSY: begin
        if (m_ack) begin
          m_req_nxt   = 1'b0;
          d_done_nxt  = 1'b1;
          d_rdata_nxt = m_we ? '0 : load_val;
          state_nxt   = IDLE;
        end else if (timed_out) begin
          m_req_nxt   = 1'b0;
          d_done_nxt  = 1'b1;
          d_err_nxt   = 1'b1;
          d_rdata_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end

      D_ERR: begin
        d_done_nxt  = 1'b1;
        d_err_nxt   = 1'b1;
        d_rdata_nxt = '0;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      cnt     <= '0;
      off     <= '0;
      size    <= '0;
      uns     <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_d  <= last_d_nxt;
      cnt     <= cnt_nxt;
      off     <= off_nxt;
      size    <= size_nxt;
      uns     <= uns_nxt;
      m_req   <= m_req_nxt;
      m_we    <= m_we_nxt;
      m_addr  <= m_addr_nxt;
      m_wdata <= m_wdata_nxt;
      m_be    <= m_be_nxt;
      i_rdata <= i_rdata_nxt;
      d_rdata <= d_rdata_nxt;
      i_done  <= i_done_nxt;
      d_done  <= d_done_nxt;
      i_err   <= i_err_nxt;
      d_err   <= d_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_request_arbiter
//  Description : Scoreboard bench for mem_request_arbiter (TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_request_arbiter;

  logic        CLK, nRST;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done, i_err;
  logic        d_req, d_we, d_unsigned;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_done, d_err;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        stall;

  mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] data;
    logic        err;
  } done_t;

  bus_t        exp_bus[$];
  done_t       exp_i[$];
  done_t       exp_d[$];
  logic [31:0] resp_q[$];

  int total = 0;
  int bad   = 0;
  int ack_delay = -1;
  int cyc = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Memory responder: ack after ack_delay cycles of m_req, data from resp_q.
  initial begin
    int wcnt;
    wcnt = 0;
    m_ack = 0;
    m_rdata = 0;
    forever begin
      @(negedge CLK);
      if (m_req && nRST) begin
        if (wcnt == ack_delay && resp_q.size() > 0) begin
          m_ack = 1;
          m_rdata = resp_q.pop_front();
        end else begin
          m_ack = 0;
        end
        wcnt++;
      end else begin
        m_ack = 0;
        wcnt = 0;
      end
    end
  end

  // Monitor: compares bus requests and completions against the scoreboard.
  initial begin
    logic prev_mreq;
    bus_t cur;
    done_t e;
    prev_mreq = 0;
    cur = '{addr: 0, we: 0, be: 0, wdata: 0};
    forever begin
      @(negedge CLK);
      if (m_req && !prev_mreq) begin
        if (exp_bus.size() == 0) begin
          check("unexpected_m_req", 32'(m_addr), 32'hFFFF_FFFF);
        end else begin
          cur = exp_bus.pop_front();
          check("m_addr", m_addr, cur.addr);
          check("m_we", 32'(m_we), 32'(cur.we));
          check("m_be", 32'(m_be), 32'(cur.be));
          check("m_wdata", m_wdata, cur.wdata);
        end
      end else if (m_req) begin
        check("m_hold_addr", m_addr, cur.addr);
        check("m_hold_be", 32'(m_be), 32'(cur.be));
      end
      prev_mreq = m_req;
      if (i_done) begin
        if (exp_i.size() == 0) begin
          check("unexpected_i_done", 32'(i_done), 32'h0);
        end else begin
          e = exp_i.pop_front();
          if (e.chk) check({e.name, "_i_rdata"}, i_rdata, e.data);
          check({e.name, "_i_err"}, 32'(i_err), 32'(e.err));
        end
      end else if (i_err) begin
        check("i_err_without_done", 32'(i_err), 32'h0);
      end
      if (d_done) begin
        if (exp_d.size() == 0) begin
          check("unexpected_d_done", 32'(d_done), 32'h0);
        end else begin
          e = exp_d.pop_front();
          if (e.chk) check({e.name, "_d_rdata"}, d_rdata, e.data);
          check({e.name, "_d_err"}, 32'(d_err), 32'(e.err));
        end
      end else if (d_err) begin
        check("d_err_without_done", 32'(d_err), 32'h0);
      end
    end
  end

  // Wait (bounded) for one side's done; checks latency and m_req cycle count.
  task automatic wait_done(input bit is_d, input int e_lat, input int e_mq, input string name);
    int n;
    int mq;
    bit seen;
    n = 0; mq = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(negedge CLK);
      n++;
      if (m_req) mq++;
      if (is_d ? d_done : i_done) seen = 1;
    end
    if (is_d) d_req = 0; else i_req = 0;
    check({name, "_done_seen"}, 32'(seen), 32'h1);
    if (seen) begin
      check({name, "_latency"}, n, e_lat);
      check({name, "_mreq_cycles"}, mq, e_mq);
    end
  endtask

  task automatic run_i(input string name, input logic [31:0] addr, input int delay,
                       input logic [31:0] mem, input logic [31:0] e_addr,
                       input logic [31:0] e_data, input logic e_err,
                       input int e_lat, input int e_mq);
    exp_bus.push_back('{addr: e_addr, we: 1'b0, be: 4'hF, wdata: 32'h0});
    if (delay >= 0) resp_q.push_back(mem);
    exp_i.push_back('{name: name, chk: 1'b1, data: e_data, err: e_err});
    ack_delay = delay;
    @(negedge CLK);
    i_req = 1; i_addr = addr;
    #1 check({name, "_stall"}, 32'(stall), 32'h1);
    wait_done(0, e_lat, e_mq, name);
  endtask

  task automatic run_d(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input int delay, input logic [31:0] mem, input logic on_bus,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, input logic chk,
                       input logic [31:0] e_rdata, input logic e_err,
                       input int e_lat, input int e_mq);
    if (on_bus) begin
      exp_bus.push_back('{addr: e_addr, we: we, be: e_be, wdata: e_wdata});
      if (delay >= 0) resp_q.push_back(mem);
    end
    exp_d.push_back('{name: name, chk: chk, data: e_rdata, err: e_err});
    ack_delay = delay;
    @(negedge CLK);
    d_req = 1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    #1 check({name, "_stall"}, 32'(stall), 32'h1);
    wait_done(1, e_lat, e_mq, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti, td, n;
    bit si, sd;
    nRST = 0;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_size = 0; d_unsigned = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge CLK);
    check("rst_m_req", 32'(m_req), 32'h0);
    check("rst_bus", {m_we, m_be, 27'h0}, 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_done_err", {28'h0, i_done, d_done, i_err, d_err}, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_rdata", i_rdata | d_rdata, 32'h0);
    nRST = 1;
    @(negedge CLK);

    // Fetches; ack on the 4th m_req cycle coincides with the timeout limit and wins.
    run_i("fetch100", 32'h100, 3, 32'h0050_0093, 32'h100, 32'h0050_0093, 0, 5, 4);
    run_i("fetch107", 32'h107, 0, 32'h1234_5678, 32'h104, 32'h1234_5678, 0, 2, 1);

    // Simultaneous requests: data first (last grant was fetch), then fetch.
    exp_bus.push_back('{addr: 32'h500, we: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_bus.push_back('{addr: 32'h600, we: 1'b0, be: 4'hF, wdata: 32'h0});
    resp_q.push_back(32'h1122_3344);
    resp_q.push_back(32'hCAFE_F00D);
    exp_d.push_back('{name: "both_d", chk: 1'b1, data: 32'h1122_3344, err: 1'b0});
    exp_i.push_back('{name: "both_i", chk: 1'b1, data: 32'hCAFE_F00D, err: 1'b0});
    ack_delay = 0;
    @(negedge CLK);
    i_req = 1; i_addr = 32'h600;
    d_req = 1; d_we = 0; d_size = 2'b10; d_unsigned = 0; d_addr = 32'h500; d_wdata = 0;
    ti = 0; td = 0; si = 0; sd = 0; n = 0;
    while (n < 40 && !(si && sd)) begin
      @(negedge CLK);
      n++;
      if (d_done && !sd) begin sd = 1; td = cyc; d_req = 0; end
      if (i_done && !si) begin si = 1; ti = cyc; i_req = 0; end
    end
    check("both_seen", {30'h0, si, sd}, 32'h3);
    check("both_d_first_gap", ti - td, 2);
    i_req = 0; d_req = 0;

    // Stores
    run_d("sb203", 1, 2'b00, 0, 32'h203, 32'h0000_00AB, 1, 32'h0, 1,
          32'h200, 4'b1000, 32'hABAB_ABAB, 0, 32'h0, 0, 3, 2);
    run_d("sh102", 1, 2'b01, 0, 32'h102, 32'h1234_BEEF, 0, 32'h0, 1,
          32'h100, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0, 0, 2, 1);
    run_d("sw040", 1, 2'b10, 0, 32'h040, 32'hDEAD_BEEF, 0, 32'h0, 1,
          32'h040, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0, 0, 2, 1);

    // Loads
    run_d("lh302", 0, 2'b01, 0, 32'h302, 32'h0, 0, 32'h8001_1234, 1,
          32'h300, 4'b1100, 32'h0, 1, 32'hFFFF_8001, 0, 2, 1);
    run_d("lhu302", 0, 2'b01, 1, 32'h302, 32'h0, 2, 32'h8001_1234, 1,
          32'h300, 4'b1100, 32'h0, 1, 32'h0000_8001, 0, 4, 3);
    run_d("lb301", 0, 2'b00, 0, 32'h301, 32'h0, 0, 32'h8001_1234, 1,
          32'h300, 4'b0010, 32'h0, 1, 32'h0000_0012, 0, 2, 1);
    run_d("lb303", 0, 2'b00, 0, 32'h303, 32'h0, 0, 32'h8001_1234, 1,
          32'h300, 4'b1000, 32'h0, 1, 32'hFFFF_FF80, 0, 2, 1);
    run_d("lbu303", 0, 2'b00, 1, 32'h303, 32'h0, 0, 32'h8001_1234, 1,
          32'h300, 4'b1000, 32'h0, 1, 32'h0000_0080, 0, 2, 1);

    // Misaligned / illegal: no bus request, error two cycles after request.
    run_d("lw401", 0, 2'b10, 0, 32'h401, 32'h0, 0, 32'h0, 0,
          32'h0, 4'h0, 32'h0, 0, 32'h0, 1, 2, 0);
    run_d("lh411", 0, 2'b01, 0, 32'h411, 32'h0, 0, 32'h0, 0,
          32'h0, 4'h0, 32'h0, 0, 32'h0, 1, 2, 0);
    run_d("sz11", 1, 2'b11, 0, 32'h420, 32'h5, 0, 32'h0, 0,
          32'h0, 4'h0, 32'h0, 0, 32'h0, 1, 2, 0);

    // Timeouts (TIMEOUT=4): m_req held 4 cycles, error with zero data.
    run_i("fetch_to", 32'h700, -1, 32'h0, 32'h700, 32'h0, 1, 5, 4);
    run_d("sw_to", 1, 2'b10, 0, 32'h900, 32'h0BAD_F00D, -1, 32'h0, 1,
          32'h900, 4'b1111, 32'h0BAD_F00D, 1, 32'h0, 1, 5, 4);

    // Reset in the middle of an unacknowledged fetch.
    exp_bus.push_back('{addr: 32'hA00, we: 1'b0, be: 4'hF, wdata: 32'h0});
    ack_delay = -1;
    @(negedge CLK);
    i_req = 1; i_addr = 32'hA00;
    @(negedge CLK);
    @(negedge CLK);
    check("rstmid_mreq_before", 32'(m_req), 32'h1);
    #2 nRST = 0;
    #1 check("rstmid_mreq_drop", 32'(m_req), 32'h0);
    check("rstmid_no_done", 32'(i_done), 32'h0);
    i_req = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
    repeat (3) @(negedge CLK);
    check("rstmid_stall", 32'(stall), 32'h0);

    // Normal operation after reset.
    run_i("fetch800", 32'h800, 1, 32'h5555_AAAA, 32'h800, 32'h5555_AAAA, 0, 3, 2);

    repeat (3) @(negedge CLK);
    check("left_bus", exp_bus.size(), 0);
    check("left_i", exp_i.size(), 0);
    check("left_d", exp_d.size(), 0);
    check("left_resp", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
